semi_auto_nav: RTL and testbench
================================

Name: semi_auto_nav

Overview:
- Semi-automatic driving controller that sequences the car's motion-command fields (move_forward, turn_left, turn_right) from detector feedback and one-shot driver direction requests.
- Sits between the detector outputs returned over UART and the command byte sent to the car.
- Active only while the top-level driving FSM asserts en; the top level muxes these command bits into the UART byte in place of the manual switches.

Parameters:
- TURN90_CYCLES, 90_000_000, cycles turn_left/turn_right is held for a 90-degree turn; 180-degree turn uses 2*TURN90_CYCLES.
- SETTLE_CYCLES, 40_000_000, cycles of forced forward motion after a turn or forward request, so the car clears the intersection.
- FILT_CYCLES, 1_000_000, cycles a synchronised detector must differ from its filtered value before the filtered value updates.
- CNT_W, 28, width of the turn/settle counter; must hold 2*TURN90_CYCLES.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  semi-auto mode enable, level.
- det_front/det_back/det_left/det_right  in  1 each  raw detectors, 1 = obstacle; asynchronous to sys_clk.
- fwd_req, left_req, right_req, back_req  in  1 each  single-cycle direction request pulses, already debounced.
- move_forward  out  1  registered forward command.
- turn_left  out  1  registered left-turn command.
- turn_right  out  1  registered right-turn command.
- busy  out  1  high in TURN or SETTLE.
- nav_state  out  3  current state encoding, for the LEDs and 7-segment display.

Behaviour:
- Reset values: state IDLE, all outputs 0, filtered detectors 4'b1111 (blocked), counters 0.
- Detector path: 2-flop synchroniser, then filter. The filtered bit flips after FILT_CYCLES consecutive differing samples; any agreeing sample clears the count. Total latency is 2 + FILT_CYCLES cycles.
- States: IDLE=0, CRUISE=1, WAIT_CMD=2, TURN=3, SETTLE=4. Other encodings go to IDLE.
- IDLE: all commands 0. en=1 -> CRUISE.
- CRUISE: move_forward=1. Goes to WAIT_CMD when filtered front=1, or when filtered left=0 or right=0 (intersection).
- WAIT_CMD: all commands 0. Requests are sampled each cycle. Accepted requests, highest priority first:
  - fwd_req with front open -> SETTLE.
  - left_req with left open -> TURN(left, TURN90_CYCLES).
  - right_req with right open -> TURN(right, TURN90_CYCLES).
  - back_req, always accepted -> TURN(left, 2*TURN90_CYCLES).
  - Requests toward a blocked side are dropped, not queued. Requests in any other state are ignored.
- TURN: the selected turn bit is 1 for exactly the loaded count of cycles; move_forward=0. The counter counts down; at 1 -> SETTLE.
- SETTLE: move_forward=1 for exactly SETTLE_CYCLES cycles; detectors are ignored. Then -> CRUISE.
- Outputs are registered from next_state. A command change appears on the same edge the state changes, i.e. 1 cycle after the triggering input.
- en=0 in any state -> IDLE and all commands 0 on the next edge; counters clear. en re-assert restarts at CRUISE, and any turn in progress is abandoned.
- Invariant: at most one of move_forward/turn_left/turn_right is 1 in any cycle.
- Dead end (front, left, right all blocked): only back_req is accepted.
- Async reset mid-TURN: outputs drop to 0 immediately, without waiting for a clock.

Optional Feature:
- Macro: SEMI_AUTO_DECIDE_EN.
- Defined: in WAIT_CMD, if exactly one of {front, left, right} is open, that move is taken 1 cycle after entry with no request needed. If none is open, a 180-degree turn is taken automatically. Two or more open still waits for a request.
- Not defined: WAIT_CMD waits indefinitely for a request.

Decomposition:
- Package nav_pkg holds:
  - state encodings IDLE..SETTLE (3-bit localparams);
  - direction codes DIR_LEFT/DIR_RIGHT;
  - the detector bit-order constant, matching the rec[3:0] order {right, left, back, front}.
- Sub-module det_filter: 2-flop sync plus stability filter, parameterised by FILT_CYCLES. Instantiated 4 times.

Test Plan (TURN90_CYCLES=8, SETTLE_CYCLES=4, FILT_CYCLES=3):
- Reset, en=1, all detectors 0 except left/right=1 -> nav_state=1, move_forward=1 from the 2nd cycle; no turn bits ever.
- In CRUISE, det_front=1 held -> WAIT_CMD 6 cycles later (2 sync + 3 filter + 1 register), all commands 0.
- WAIT_CMD with left open, pulse left_req -> turn_left=1 for exactly 8 cycles, then move_forward=1 for exactly 4, then CRUISE.
- WAIT_CMD with right blocked, right_req -> ignored, state stays 2. Then back_req -> turn_left=1 for exactly 16 cycles.
- fwd_req and left_req in the same cycle, both sides open -> SETTLE taken, turn_left never asserts.
- en=0 at cycle 3 of TURN -> next edge IDLE, all outputs 0. With SEMI_AUTO_DECIDE_EN, only right open -> turn_right asserts 1 cycle after entering WAIT_CMD.

Source files
------------

// File: rtl/nav_pkg.sv
// Shared constants for the semi-automatic navigation controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package nav_pkg;

    // Sequencer state encodings, also shown on the LEDs / 7-segment display
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CRUISE   = 3'd1;
    localparam logic [2:0] WAIT_CMD = 3'd2;
    localparam logic [2:0] TURN     = 3'd3;
    localparam logic [2:0] SETTLE   = 3'd4;

    // Turn direction codes
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Detector bit positions, matching the UART rec[3:0] order {right, left, back, front}
    localparam int DET_FRONT = 0;
    localparam int DET_BACK  = 1;
    localparam int DET_LEFT  = 2;
    localparam int DET_RIGHT = 3;

    // The car is committed to a manoeuvre in these states
    function automatic logic is_busy(input logic [2:0] st);
        return (st == TURN) || (st == SETTLE);
    endfunction

endpackage

// File: rtl/det_filter.sv
// Detector conditioner: 2-flop synchroniser followed by a stability filter.
// Latency: 2 + FILT_CYCLES cycles from a raw change to the filtered output.
// Backpressure: none; free-running, resets to 1 (obstacle assumed).
module det_filter #(
    parameter int FILT_CYCLES = 1_000_000
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);

    localparam int CW = $clog2(FILT_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Bring the asynchronous detector into the sys_clk domain
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Flip the filtered value only after FILT_CYCLES consecutive disagreeing samples
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            filt <= 1'b1;
            cnt  <= '0;
        end else if (sync2 == filt) begin
            cnt <= '0;
        end else if (cnt == CW'(FILT_CYCLES - 1)) begin
            filt <= sync2;
            cnt  <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/semi_auto_nav.sv
// Semi-automatic driving sequencer: cruise, stop at junctions, turn/settle on driver request.
// Latency: commands are registered from next state, 1 cycle after the triggering input.
// Backpressure: none; requests outside WAIT_CMD or toward a blocked side are dropped.
// Build option: SEMI_AUTO_DECIDE_EN lets WAIT_CMD pick the only open move (or a U-turn) unaided.
module semi_auto_nav
    import nav_pkg::*;
#(
    parameter int TURN90_CYCLES = 90_000_000,
    parameter int SETTLE_CYCLES = 40_000_000,
    parameter int FILT_CYCLES   = 1_000_000,
    parameter int CNT_W         = 28
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       en,
    input  logic       det_front,
    input  logic       det_back,
    input  logic       det_left,
    input  logic       det_right,
    input  logic       fwd_req,
    input  logic       left_req,
    input  logic       right_req,
    input  logic       back_req,
    output logic       move_forward,
    output logic       turn_left,
    output logic       turn_right,
    output logic       busy,
    output logic [2:0] nav_state
);

    localparam logic [CNT_W-1:0] TURN90_LD  = CNT_W'(TURN90_CYCLES);
    localparam logic [CNT_W-1:0] TURN180_LD = CNT_W'(2 * TURN90_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYCLES);

    logic [3:0]       det_raw;
    logic [3:0]       det_filt;
    logic             front_open, left_open, right_open;
    logic             unused_back;
    logic             take_fwd, take_left, take_right, take_back;
    logic [2:0]       state, next_state;
    logic [CNT_W-1:0] cnt, next_cnt;
    logic             dir, next_dir;

    assign det_raw[DET_FRONT] = det_front;
    assign det_raw[DET_BACK]  = det_back;
    assign det_raw[DET_LEFT]  = det_left;
    assign det_raw[DET_RIGHT] = det_right;

    for (genvar i = 0; i < 4; i++) begin : g_det
        det_filter #(.FILT_CYCLES(FILT_CYCLES)) u_det_filter (
            .sys_clk (sys_clk),
            .rst     (rst),
            .raw     (det_raw[i]),
            .filt    (det_filt[i])
        );
    end

    assign front_open  = ~det_filt[DET_FRONT];
    assign left_open   = ~det_filt[DET_LEFT];
    assign right_open  = ~det_filt[DET_RIGHT];
    // The rear detector is conditioned with the rest but the sequencer never consults it
    assign unused_back = det_filt[DET_BACK];

`ifdef SEMI_AUTO_DECIDE_EN
    logic [1:0] n_open;
    logic       manual;
    assign n_open     = {1'b0, front_open} + {1'b0, left_open} + {1'b0, right_open};
    assign manual     = (n_open >= 2'd2);
    assign take_fwd   = manual ? (fwd_req & front_open)  : front_open;
    assign take_left  = manual ? (left_req & left_open)  : left_open;
    assign take_right = manual ? (right_req & right_open) : right_open;
    assign take_back  = manual ? back_req : (n_open == 2'd0);
`else
    assign take_fwd   = fwd_req & front_open;
    assign take_left  = left_req & left_open;
    assign take_right = right_req & right_open;
    assign take_back  = back_req;
`endif

    // Next-state, counter and direction selection
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_dir   = dir;
        if (!en) begin
            next_state = IDLE;
            next_cnt   = '0;
            next_dir   = DIR_LEFT;
        end else begin
            case (state)
                IDLE:     next_state = CRUISE;
                CRUISE:   if (!front_open || left_open || right_open) next_state = WAIT_CMD;
                WAIT_CMD: begin
                    if (take_fwd) begin
                        next_state = SETTLE;
                        next_cnt   = SETTLE_LD;
                    end else if (take_left) begin
                        next_state = TURN;
                        next_cnt   = TURN90_LD;
                        next_dir   = DIR_LEFT;
                    end else if (take_right) begin
                        next_state = TURN;
                        next_cnt   = TURN90_LD;
                        next_dir   = DIR_RIGHT;
                    end else if (take_back) begin
                        next_state = TURN;
                        next_cnt   = TURN180_LD;
                        next_dir   = DIR_LEFT;
                    end
                end
                TURN: begin
                    if (cnt <= CNT_W'(1)) begin
                        next_state = SETTLE;
                        next_cnt   = SETTLE_LD;
                    end else begin
                        next_cnt = cnt - CNT_W'(1);
                    end
                end
                SETTLE: begin
                    if (cnt <= CNT_W'(1)) begin
                        next_state = CRUISE;
                        next_cnt   = '0;
                    end else begin
                        next_cnt = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end
            endcase
        end
    end

    // State plus commands registered from next state so they switch on the same edge
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            dir          <= DIR_LEFT;
            move_forward <= 1'b0;
            turn_left    <= 1'b0;
            turn_right   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= next_state;
            cnt          <= next_cnt;
            dir          <= next_dir;
            move_forward <= (next_state == CRUISE) || (next_state == SETTLE);
            turn_left    <= (next_state == TURN) && (next_dir == DIR_LEFT);
            turn_right   <= (next_state == TURN) && (next_dir == DIR_RIGHT);
            busy         <= is_busy(next_state);
        end
    end

    assign nav_state = state;

endmodule

// File: tb/tb_semi_auto_nav.sv
// Self-checking bench for semi_auto_nav with short turn/settle/filter timings.
// Latency: n/a.
// Backpressure: n/a.
module tb_semi_auto_nav;

    localparam int T90 = 8;
    localparam int TS  = 4;
    localparam int TF  = 3;

    logic       sys_clk = 1'b0;
    logic       rst, en;
    logic       det_front, det_back, det_left, det_right;
    logic       fwd_req, left_req, right_req, back_req;
    logic       move_forward, turn_left, turn_right, busy;
    logic [2:0] nav_state;

    int errors = 0;
    int checks = 0;

    always #5 sys_clk = ~sys_clk;

    semi_auto_nav #(
        .TURN90_CYCLES (T90),
        .SETTLE_CYCLES (TS),
        .FILT_CYCLES   (TF),
        .CNT_W         (28)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .en           (en),
        .det_front    (det_front),
        .det_back     (det_back),
        .det_left     (det_left),
        .det_right    (det_right),
        .fwd_req      (fwd_req),
        .left_req     (left_req),
        .right_req    (right_req),
        .back_req     (back_req),
        .move_forward (move_forward),
        .turn_left    (turn_left),
        .turn_right   (turn_right),
        .busy         (busy),
        .nav_state    (nav_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample just after the edge, check the command invariants
    task automatic tick();
        @(posedge sys_clk);
        #1;
        chk("onehot_cmds", 32'($onehot0({move_forward, turn_left, turn_right})), 1);
        chk("busy_state", 32'(busy), 32'((nav_state == 3'd3) || (nav_state == 3'd4)));
    endtask

    task automatic settle_dets();
        repeat (TF + 4) tick();
    endtask

    // r = {fwd, left, right, back}, one-cycle pulse
    task automatic pulse(input logic [3:0] r);
        {fwd_req, left_req, right_req, back_req} = r;
        tick();
        {fwd_req, left_req, right_req, back_req} = 4'b0000;
    endtask

    // Reference decision: 0 none, 1 forward, 2 left 90, 3 right 90, 4 U-turn
    function automatic int decide(input bit fo, input bit lo, input bit ro, input logic [3:0] r);
        if (r[3] && fo) return 1;
        if (r[2] && lo) return 2;
        if (r[1] && ro) return 3;
        if (r[0])       return 4;
        return 0;
    endfunction

    function automatic int act_now(input logic [3:0] r);
        return decide(!det_front, !det_left, !det_right, r);
    endfunction

    // Measure the manoeuvre started by the last pulse and compare with the expected action
    task automatic expect_action(input string tag, input int act);
        int tl, tr, st;
        tl = 0; tr = 0; st = 0;
        if (act == 0) begin
            chk({tag, "_stay"}, 32'(nav_state), 2);
            chk({tag, "_cmds"}, 32'({move_forward, turn_left, turn_right}), 0);
            tick();
            chk({tag, "_stay2"}, 32'(nav_state), 2);
        end else begin
            for (int i = 0; i < 64 && (turn_left || turn_right); i++) begin
                if (turn_left)  tl++;
                if (turn_right) tr++;
                tick();
            end
            for (int i = 0; i < 64 && nav_state == 3'd4; i++) begin
                st++;
                chk({tag, "_settle_fwd"}, 32'(move_forward), 1);
                tick();
            end
            chk({tag, "_left_len"}, tl, (act == 2) ? T90 : (act == 4) ? 2 * T90 : 0);
            chk({tag, "_right_len"}, tr, (act == 3) ? T90 : 0);
            chk({tag, "_settle_len"}, st, TS);
            chk({tag, "_cruise"}, 32'(nav_state), 1);
        end
    endtask

    initial begin
        logic [3:0] r;
        int         act;
        rst = 1'b1; en = 1'b0;
        det_front = 1'b0; det_back = 1'b0; det_left = 1'b1; det_right = 1'b1;
        {fwd_req, left_req, right_req, back_req} = 4'b0000;
        #2 rst = 1'b0;
        #10;
        chk("rst_state", 32'(nav_state), 0);
        chk("rst_cmds", 32'({move_forward, turn_left, turn_right, busy}), 0);
        #9 rst = 1'b1;

        settle_dets();
        chk("idle_state", 32'(nav_state), 0);
        chk("idle_cmds", 32'({move_forward, turn_left, turn_right}), 0);

        en = 1'b1;
        tick();
        chk("cruise_state", 32'(nav_state), 1);
        chk("cruise_fwd", 32'(move_forward), 1);
        repeat (3) tick();
        chk("cruise_hold", 32'(nav_state), 1);

`ifdef SEMI_AUTO_DECIDE_EN
        det_front = 1'b1; det_right = 1'b0;
        repeat (6) tick();
        chk("auto_wait", 32'(nav_state), 2);
        tick();
        chk("auto_turn_state", 32'(nav_state), 3);
        chk("auto_turn_right", 32'(turn_right), 1);
`else
        // Front obstacle: 2 sync + 3 filter + 1 register
        det_front = 1'b1;
        repeat (5) tick();
        chk("front_early", 32'(nav_state), 1);
        tick();
        chk("front_wait", 32'(nav_state), 2);
        chk("front_cmds", 32'({move_forward, turn_left, turn_right}), 0);

        // Left 90-degree turn
        det_left = 1'b0;
        settle_dets();
        chk("wait_hold", 32'(nav_state), 2);
        pulse(4'b0100);
        expect_action("left90", act_now(4'b0100));
        tick();
        chk("left90_rewait", 32'(nav_state), 2);

        // Right blocked: dropped; then U-turn
        pulse(4'b0010);
        expect_action("right_blocked", act_now(4'b0010));
        pulse(4'b0001);
        expect_action("uturn", act_now(4'b0001));
        tick();
        chk("uturn_rewait", 32'(nav_state), 2);

        // Forward beats left when both are open
        det_front = 1'b0;
        settle_dets();
        pulse(4'b1100);
        chk("fwd_prio_state", 32'(nav_state), 4);
        chk("fwd_prio_noleft", 32'(turn_left), 0);
        expect_action("fwd_prio", act_now(4'b1100));
        tick();
        chk("fwd_prio_rewait", 32'(nav_state), 2);

        // Dead end: only the U-turn is possible
        det_front = 1'b1; det_left = 1'b1; det_right = 1'b1;
        settle_dets();
        pulse(4'b1110);
        expect_action("deadend", act_now(4'b1110));

        // Randomised junctions and request mixes
        for (int k = 0; k < 10; k++) begin
            det_front = 1'($urandom_range(0, 1));
            det_left  = 1'($urandom_range(0, 1));
            det_right = 1'($urandom_range(0, 1));
            if (!det_front && det_left && det_right) det_front = 1'b1;
            settle_dets();
            chk("rnd_wait", 32'(nav_state), 2);
            r   = 4'($urandom_range(0, 15));
            act = act_now(r);
            pulse(r);
            expect_action("rnd", act);
            if (act != 0) tick();
            chk("rnd_rewait", 32'(nav_state), 2);
        end

        // Enable dropped on the 3rd cycle of a turn
        det_front = 1'b1; det_left = 1'b0;
        settle_dets();
        pulse(4'b0100);
        chk("en_turn_start", 32'(turn_left), 1);
        repeat (2) tick();
        en = 1'b0;
        tick();
        chk("en_off_state", 32'(nav_state), 0);
        chk("en_off_cmds", 32'({move_forward, turn_left, turn_right, busy}), 0);
        en = 1'b1;
        tick();
        chk("en_on_state", 32'(nav_state), 1);
        chk("en_on_fwd", 32'(move_forward), 1);
        tick();
        chk("en_on_wait", 32'(nav_state), 2);

        // Asynchronous reset mid-turn clears outputs before any clock edge
        pulse(4'b0100);
        chk("arst_pre", 32'(turn_left), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_left", 32'(turn_left), 0);
        chk("arst_state", 32'(nav_state), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
